// File: rtl/hold_pkg.sv
// Shared constants and types for the climbing-wall hold store.
// Default layout holds the standard 15-hold wall; remaining slots are parked off-wall by the top.
package hold_pkg;

    localparam int MAX_HOLDS      = 64;
    localparam int HOLD_DEFAULT_N = 15;

    localparam int HOLD_X0 [MAX_HOLDS] = '{
        0: 400,  1: 300,  2: 580,  3: 300,  4: 700,
        5: 450,  6: 600,  7: 640,  8: 300,  9: 250,
        10: 375, 11: 500, 12: 530, 13: 580, 14: 650,
        default: 0
    };

    localparam int HOLD_Y0 [MAX_HOLDS] = '{
        0: 50,     1: 100,    2: 400,    3: 600,    4: 200,
        5: -550,   6: -450,   7: -200,   8: -1000,  9: 300,
        10: -1500, 11: -1200, 12: -1400, 13: -1600, 14: -700,
        default: 0
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hold_dist2.sv
// Combinational hand-to-hold proximity test: dx*dx + dy*dy < GRAB_R2.
// Squares are taken on magnitudes so the unsigned sum never overflows.
module hold_dist2
    import hold_pkg::*;
#(
    parameter int XW      = 12,
    parameter int YW      = 13,
    parameter int GRAB_R2 = 150
)(
    input  logic signed [XW:0]   hwx_i,
    input  logic signed [YW:0]   hwy_i,
    input  logic signed [XW-1:0] hx_i,
    input  logic signed [YW-1:0] hy_i,
    output logic                 near_o
);

    localparam int SW = 2 * (YW + 1) + 1;

    logic signed [XW:0] dx;
    logic signed [YW:0] dy;
    logic        [XW:0] adx;
    logic        [YW:0] ady;
    logic      [SW-1:0] sum;

    always_comb begin
        dx     = hwx_i - {hx_i[XW-1], hx_i};
        dy     = hwy_i - {hy_i[YW-1], hy_i};
        adx    = dx[XW] ? -dx : dx;
        ady    = dy[YW] ? -dy : dy;
        sum    = SW'(adx) * SW'(adx) + SW'(ady) * SW'(ady);
        near_o = (sum < SW'(GRAB_R2));
    end

endmodule

// File: rtl/hold_table.sv
// Hold store for the climbing wall: draws holds per pixel, scans hand contact once per frame,
// and lets hand 1 carry a hold in map-edit mode.
module hold_table
    import hold_pkg::*;
#(
    parameter  int NUM_HOLDS = 16,
    parameter  int HOLD_R    = 8,
    parameter  int GRAB_R2   = 150,
    parameter  int XW        = 12,
    parameter  int YW        = 13,
    localparam int IW        = $clog2(NUM_HOLDS)
)(
    input  logic                 vclock,
    input  logic                 reset_n,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic signed [XW-1:0] screenx,
    input  logic signed [YW-1:0] screeny,
    input  logic                 frame_start,
    input  logic                 edit_mode,
    input  logic [10:0]          hand1x,
    input  logic [9:0]           hand1y,
    input  logic [10:0]          hand2x,
    input  logic [9:0]           hand2y,
    input  logic                 grab1,
    input  logic                 grab2,
    output logic                 exists,
    output logic [IW-1:0]        exists_idx,
    output logic                 hand1_on,
    output logic                 hand2_on,
    output logic [IW-1:0]        hand1_idx,
    output logic [IW-1:0]        hand2_idx,
    output logic                 carrying,
    output logic [IW-1:0]        carry_idx,
    output logic                 scan_busy
);

    localparam logic signed [YW-1:0] PARK_Y = {1'b1, {(YW-1){1'b0}}};

    logic signed [XW-1:0] hx_q [NUM_HOLDS];
    logic signed [YW-1:0] hy_q [NUM_HOLDS];
    logic signed [XW-1:0] hx_d [NUM_HOLDS];
    logic signed [YW-1:0] hy_d [NUM_HOLDS];

    logic signed [XW:0] wx, hw1x, hw2x;
    logic signed [YW:0] wy, hw1y, hw2y;

    logic [NUM_HOLDS-1:0] pix_hit;
    logic                 pix_any;
    logic [IW-1:0]        pix_idx;
    logic                 exists_q;
    logic [IW-1:0]        exists_idx_q;

    scan_state_e   state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic          h1_found_q, h1_found_d, h2_found_q, h2_found_d;
    logic [IW-1:0] h1_fidx_q, h1_fidx_d, h2_fidx_q, h2_fidx_d;
    logic          h1_on_q, h1_on_d, h2_on_q, h2_on_d;
    logic [IW-1:0] h1_idx_q, h1_idx_d, h2_idx_q, h2_idx_d;
    logic          near1, near2, scan_done;
    logic          new1_on, new2_on;
    logic [IW-1:0] new1_idx, new2_idx;

    logic          carrying_q, carrying_d, move;
    logic [IW-1:0] carry_idx_q, carry_idx_d;

    logic unused_grab2;
    assign unused_grab2 = grab2;

    assign wx   = {screenx[XW-1], screenx} + (XW+1)'(hcount);
    assign wy   = {screeny[YW-1], screeny} + (YW+1)'(vcount);
    assign hw1x = {screenx[XW-1], screenx} + (XW+1)'(hand1x);
    assign hw1y = {screeny[YW-1], screeny} + (YW+1)'(hand1y);
    assign hw2x = {screenx[XW-1], screenx} + (XW+1)'(hand2x);
    assign hw2y = {screeny[YW-1], screeny} + (YW+1)'(hand2y);

    for (genvar g = 0; g < NUM_HOLDS; g++) begin : g_pix
        logic signed [XW:0] pdx;
        logic signed [YW:0] pdy;
        assign pdx = wx - {hx_q[g][XW-1], hx_q[g]};
        assign pdy = wy - {hy_q[g][YW-1], hy_q[g]};
        assign pix_hit[g] = (int'(pdx) >= -HOLD_R) && (int'(pdx) <= HOLD_R) &&
                            (int'(pdy) >= -HOLD_R) && (int'(pdy) <= HOLD_R);
    end

    // Walk downwards so the lowest hit index is the one left standing.
    always_comb begin
        pix_any = 1'b0;
        pix_idx = '0;
        for (int i = NUM_HOLDS - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                pix_any = 1'b1;
                pix_idx = IW'(i);
            end
        end
    end

    hold_dist2 #(.XW(XW), .YW(YW), .GRAB_R2(GRAB_R2)) u_dist1 (
        .hwx_i (hw1x),
        .hwy_i (hw1y),
        .hx_i  (hx_q[i_q]),
        .hy_i  (hy_q[i_q]),
        .near_o(near1)
    );

    hold_dist2 #(.XW(XW), .YW(YW), .GRAB_R2(GRAB_R2)) u_dist2 (
        .hwx_i (hw2x),
        .hwy_i (hw2y),
        .hx_i  (hx_q[i_q]),
        .hy_i  (hy_q[i_q]),
        .near_o(near2)
    );

    assign scan_done = (state_q == S_SCAN) && (i_q == IW'(NUM_HOLDS - 1));
    assign new1_on   = h1_found_q | near1;
    assign new2_on   = h2_found_q | near2;
    assign new1_idx  = h1_found_q ? h1_fidx_q : i_q;
    assign new2_idx  = h2_found_q ? h2_fidx_q : i_q;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        h1_found_d = h1_found_q;
        h1_fidx_d  = h1_fidx_q;
        h2_found_d = h2_found_q;
        h2_fidx_d  = h2_fidx_q;
        h1_on_d    = h1_on_q;
        h1_idx_d   = h1_idx_q;
        h2_on_d    = h2_on_q;
        h2_idx_d   = h2_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_SCAN;
                    i_d        = '0;
                    h1_found_d = 1'b0;
                    h1_fidx_d  = '0;
                    h2_found_d = 1'b0;
                    h2_fidx_d  = '0;
                end
            end
            S_SCAN: begin
                if (near1 && !h1_found_q) begin
                    h1_found_d = 1'b1;
                    h1_fidx_d  = i_q;
                end
                if (near2 && !h2_found_q) begin
                    h2_found_d = 1'b1;
                    h2_fidx_d  = i_q;
                end
                if (scan_done) begin
                    state_d  = S_IDLE;
                    h1_on_d  = new1_on;
                    h1_idx_d = new1_on ? new1_idx : '0;
                    h2_on_d  = new2_on;
                    h2_idx_d = new2_on ? new2_idx : '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A release at frame_start takes precedence over any pick-up from the same frame.
    always_comb begin
        carrying_d  = carrying_q;
        carry_idx_d = carry_idx_q;
        move        = 1'b0;
        if (!edit_mode) begin
            carrying_d = 1'b0;
        end else if (frame_start && carrying_q) begin
            if (grab1) begin
                move = 1'b1;
            end else begin
                carrying_d = 1'b0;
            end
        end else if (scan_done && !carrying_q && grab1 && new1_on) begin
            carrying_d  = 1'b1;
            carry_idx_d = new1_idx;
        end
    end

    always_comb begin
        hx_d = hx_q;
        hy_d = hy_q;
        for (int i = 0; i < NUM_HOLDS; i++) begin
            if (move && (carry_idx_q == IW'(i))) begin
                hx_d[i] = hw1x[XW-1:0];
                hy_d[i] = hw1y[YW-1:0];
            end
        end
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_HOLDS; k++) begin
                hx_q[k] <= XW'(HOLD_X0[k]);
                hy_q[k] <= (k < HOLD_DEFAULT_N) ? YW'(HOLD_Y0[k]) : PARK_Y;
            end
            exists_q     <= 1'b0;
            exists_idx_q <= '0;
            state_q      <= S_IDLE;
            i_q          <= '0;
            h1_found_q   <= 1'b0;
            h1_fidx_q    <= '0;
            h2_found_q   <= 1'b0;
            h2_fidx_q    <= '0;
            h1_on_q      <= 1'b0;
            h1_idx_q     <= '0;
            h2_on_q      <= 1'b0;
            h2_idx_q     <= '0;
            carrying_q   <= 1'b0;
            carry_idx_q  <= '0;
        end else begin
            hx_q         <= hx_d;
            hy_q         <= hy_d;
            exists_q     <= pix_any;
            exists_idx_q <= pix_idx;
            state_q      <= state_d;
            i_q          <= i_d;
            h1_found_q   <= h1_found_d;
            h1_fidx_q    <= h1_fidx_d;
            h2_found_q   <= h2_found_d;
            h2_fidx_q    <= h2_fidx_d;
            h1_on_q      <= h1_on_d;
            h1_idx_q     <= h1_idx_d;
            h2_on_q      <= h2_on_d;
            h2_idx_q     <= h2_idx_d;
            carrying_q   <= carrying_d;
            carry_idx_q  <= carry_idx_d;
        end
    end

    assign exists     = exists_q;
    assign exists_idx = exists_idx_q;
    assign hand1_on   = h1_on_q;
    assign hand1_idx  = h1_idx_q;
    assign hand2_on   = h2_on_q;
    assign hand2_idx  = h2_idx_q;
    assign carrying   = carrying_q;
    assign carry_idx  = carry_idx_q;
    assign scan_busy  = (state_q == S_SCAN);

endmodule

// File: tb/tb_hold_table.sv
// Directed bench for hold_table: pixel hits, hand scan, edit carry and mid-scan reset.
module tb_hold_table;

    localparam int NUM_HOLDS = 16;
    localparam int IW        = 4;

    logic              vclock = 1'b0;
    logic              reset_n;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic signed [11:0] screenx;
    logic signed [12:0] screeny;
    logic              frame_start, edit_mode, grab1, grab2;
    logic [10:0]       hand1x, hand2x;
    logic [9:0]        hand1y, hand2y;
    logic              exists, hand1_on, hand2_on, carrying, scan_busy;
    logic [IW-1:0]     exists_idx, hand1_idx, hand2_idx, carry_idx;

    int   checks   = 0;
    int   failures = 0;
    logic carryAfterPulse;

    always #5 vclock = ~vclock;

    hold_table #(.NUM_HOLDS(NUM_HOLDS)) dut (
        .vclock     (vclock),
        .reset_n    (reset_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .screenx    (screenx),
        .screeny    (screeny),
        .frame_start(frame_start),
        .edit_mode  (edit_mode),
        .hand1x     (hand1x),
        .hand1y     (hand1y),
        .hand2x     (hand2x),
        .hand2y     (hand2y),
        .grab1      (grab1),
        .grab2      (grab2),
        .exists     (exists),
        .exists_idx (exists_idx),
        .hand1_on   (hand1_on),
        .hand2_on   (hand2_on),
        .hand1_idx  (hand1_idx),
        .hand2_idx  (hand2_idx),
        .carrying   (carrying),
        .carry_idx  (carry_idx),
        .scan_busy  (scan_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive a pixel position and wait one clock for the registered hit result.
    task automatic applyStimulus(input int hc, input int vc);
        hcount = 11'(hc);
        vcount = 10'(vc);
        @(negedge vclock);
    endtask

    task automatic doFrame(input int h1x, input int h1y, input int h2x, input int h2y, input logic g1);
        int n;
        hand1x      = 11'(h1x);
        hand1y      = 10'(h1y);
        hand2x      = 11'(h2x);
        hand2y      = 10'(h2y);
        grab1       = g1;
        frame_start = 1'b1;
        @(negedge vclock);
        frame_start     = 1'b0;
        carryAfterPulse = carrying;
        n = 0;
        while (scan_busy && n < 40) begin
            @(negedge vclock);
            n++;
        end
        checkOutput("scanLat", n, NUM_HOLDS);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; hcount = '0; vcount = '0; screenx = '0; screeny = '0;
        frame_start = 1'b0; edit_mode = 1'b0; grab1 = 1'b0; grab2 = 1'b0;
        hand1x = '0; hand1y = '0; hand2x = '0; hand2y = '0;
        repeat (3) @(negedge vclock);
        checkOutput("rstExists", exists, 0);
        checkOutput("rstBusy", scan_busy, 0);
        checkOutput("rstH1On", hand1_on, 0);
        checkOutput("rstCarry", carrying, 0);
        reset_n = 1'b1;
        @(negedge vclock);

        applyStimulus(400, 50);  checkOutput("pixH0", exists, 1); checkOutput("pixH0Idx", exists_idx, 0);
        applyStimulus(409, 50);  checkOutput("pixXOut", exists, 0);
        applyStimulus(408, 58);  checkOutput("pixEdgeHi", exists, 1);
        applyStimulus(392, 42);  checkOutput("pixEdgeLo", exists, 1);
        applyStimulus(400, 59);  checkOutput("pixYOut", exists, 0);
        applyStimulus(300, 100); checkOutput("pixH1Idx", exists_idx, 1);

        doFrame(305, 105, 0, 0, 1'b0);
        checkOutput("scanH1On", hand1_on, 1);
        checkOutput("scanH1Idx", hand1_idx, 1);
        checkOutput("scanH2Off", hand2_on, 0);

        doFrame(413, 50, 410, 57, 1'b1);
        checkOutput("r2Just169", hand1_on, 0);
        checkOutput("r2Just149", hand2_on, 1);
        checkOutput("r2H2Idx", hand2_idx, 0);
        checkOutput("noEditNoCarry", carrying, 0);

        screenx = 12'(100); screeny = 13'(-200);
        applyStimulus(300, 250); checkOutput("pixOffset", exists, 1); checkOutput("pixOffsetIdx", exists_idx, 0);
        doFrame(200, 300, 0, 0, 1'b0);
        checkOutput("scanOffsetOn", hand1_on, 1);
        checkOutput("scanOffsetIdx", hand1_idx, 1);
        screenx = '0; screeny = '0;

        edit_mode = 1'b1;
        doFrame(305, 105, 0, 0, 1'b1);
        checkOutput("pickCarry", carrying, 1);
        checkOutput("pickIdx", carry_idx, 1);
        doFrame(320, 200, 0, 0, 1'b1);
        checkOutput("moveStillCarry", carryAfterPulse, 1);
        checkOutput("moveScanIdx", hand1_idx, 1);
        applyStimulus(320, 200); checkOutput("movedHit", exists, 1); checkOutput("movedIdx", exists_idx, 1);
        applyStimulus(300, 100); checkOutput("oldSpotEmpty", exists, 0);

        doFrame(100, 100, 0, 0, 1'b1);
        doFrame(100, 100, 0, 0, 1'b0);
        checkOutput("releaseAtPulse", carryAfterPulse, 0);
        checkOutput("releaseNoPick", carrying, 0);
        doFrame(300, 600, 0, 0, 1'b1);
        checkOutput("pick3Idx", carry_idx, 3);
        doFrame(100, 100, 0, 0, 1'b1);
        checkOutput("overlapScanIdx", hand1_idx, 1);
        checkOutput("overlapCarryIdx", carry_idx, 3);
        applyStimulus(100, 100); checkOutput("overlapHit", exists, 1); checkOutput("overlapIdx", exists_idx, 1);
        applyStimulus(300, 600); checkOutput("h3Moved", exists, 0);
        doFrame(100, 100, 0, 0, 1'b0);
        checkOutput("release2", carryAfterPulse, 0);
        applyStimulus(108, 92);  checkOutput("holdStays", exists, 1);

        doFrame(580, 400, 0, 0, 1'b1);
        checkOutput("pick2Carry", carrying, 1);
        checkOutput("pick2Idx", carry_idx, 2);
        edit_mode = 1'b0;
        @(negedge vclock);
        checkOutput("editOffClears", carrying, 0);

        grab1 = 1'b0;
        frame_start = 1'b1;
        @(negedge vclock);
        frame_start = 1'b0;
        repeat (4) @(negedge vclock);
        checkOutput("midScanBusy", scan_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abortH1On", hand1_on, 0);
        checkOutput("abortH1Idx", hand1_idx, 0);
        checkOutput("abortBusy", scan_busy, 0);
        checkOutput("abortExists", exists, 0);
        @(negedge vclock);
        reset_n = 1'b1;
        @(negedge vclock);
        applyStimulus(300, 100); checkOutput("restoreH1", exists, 1); checkOutput("restoreH1Idx", exists_idx, 1);
        applyStimulus(300, 600); checkOutput("restoreH3Idx", exists_idx, 3);
        applyStimulus(100, 100); checkOutput("restoreEmpty", exists, 0);
        doFrame(305, 105, 0, 0, 1'b0);
        checkOutput("rescanOn", hand1_on, 1);
        checkOutput("rescanIdx", hand1_idx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
